prbs16_checker: RTL and testbench

PRBS16_CHECKER -- requirements
Module: prbs16_checker

---
 rtl/prbs16_pkg.sv | 31 +++
 rtl/prbs16_checker.sv | 139 +++++++++++++
 tb/tb_prbs16_checker.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/prbs16_pkg.sv
// Shared types and helpers for the 16-bit PRBS checker: word type, FSM states,
// generator step function and popcount.
package prbs16_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // One step of the lfsr_16 generator; the receiver predicts the next word with it.
  function automatic word_t prbs_next(input word_t q);
    word_t n;
    n     = {q[14:0], 1'b0};
    n[0]  = q[15];
    n[2]  = q[15] ^ q[1];
    n[15] = q[15] ^ q[14];
    return n;
  endfunction

  function automatic logic [4:0] popcount16(input word_t w);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, w[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prbs16_checker.sv
// PRBS16 receive checker: hunts for a seed, locks after a run of predicted words,
// then flywheels the prediction and counts word/bit errors until too many misses.
//
//  state     | meaning
//  ST_HUNT   | seeding from received words, counting consecutive predicted matches
//  ST_LOCKED | flywheeling the prediction, reporting and counting mismatches
module prbs16_checker
  import prbs16_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [15:0] word_in,
  output logic        locked_out,
  output logic        err_out,
  output logic [15:0] word_err_count_out,
  output logic [23:0] bit_err_count_out
);

  localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_COUNT);

  state_t      state_q, state_d;
  logic        seeded_q, seeded_d;
  word_t       exp_q, exp_d;
  logic [3:0]  match_q, match_d;
  logic [3:0]  miss_q, miss_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic [15:0] werr_q, werr_d;
  logic [23:0] berr_q, berr_d;

  word_t       diff;
  logic [4:0]  diff_bits;
  logic [3:0]  match_inc;
  logic [3:0]  miss_inc;
  logic [15:0] werr_inc;
  logic [24:0] berr_sum;
  logic [23:0] berr_inc;

  assign diff      = word_in ^ exp_q;
  assign diff_bits = popcount16(diff);
  assign match_inc = match_q + 4'd1;
  assign miss_inc  = miss_q + 4'd1;
  assign werr_inc  = (werr_q == 16'hFFFF) ? werr_q : werr_q + 16'd1;
  assign berr_sum  = {1'b0, berr_q} + {20'd0, diff_bits};
  assign berr_inc  = berr_sum[24] ? 24'hFFFFFF : berr_sum[23:0];

  always_comb begin
    state_d  = state_q;
    seeded_d = seeded_q;
    exp_d    = exp_q;
    match_d  = match_q;
    miss_d   = miss_q;
    werr_d   = werr_q;
    berr_d   = berr_q;
    err_d    = 1'b0;

    if (valid_in) begin
      case (state_q)
        ST_HUNT: begin
          // The all-zero word is the generator lock-up state: it never seeds.
          if (word_in == 16'h0000) begin
            seeded_d = 1'b0;
            match_d  = 4'd0;
          end else if (seeded_q && (word_in == exp_q)) begin
            exp_d   = prbs_next(word_in);
            match_d = match_inc;
            if (match_inc == LOCK_CNT) begin
              state_d = ST_LOCKED;
              miss_d  = 4'd0;
            end
          end else begin
            exp_d    = prbs_next(word_in);
            seeded_d = 1'b1;
            match_d  = 4'd0;
          end
        end
        ST_LOCKED: begin
          exp_d = prbs_next(exp_q);
          if (diff == 16'h0000) begin
            miss_d = 4'd0;
          end else begin
            err_d  = 1'b1;
            werr_d = werr_inc;
            berr_d = berr_inc;
            miss_d = miss_inc;
            if (miss_inc == UNLOCK_CNT) begin
              state_d = ST_HUNT;
              match_d = 4'd0;
              if (word_in == 16'h0000) begin
                seeded_d = 1'b0;
              end else begin
                seeded_d = 1'b1;
                exp_d    = prbs_next(word_in);
              end
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_HUNT;
      seeded_q <= 1'b0;
      exp_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      werr_q   <= '0;
      berr_q   <= '0;
    end else begin
      state_q  <= state_d;
      seeded_q <= seeded_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      werr_q   <= werr_d;
      berr_q   <= berr_d;
    end
  end

  assign locked_out         = locked_q;
  assign err_out            = err_q;
  assign word_err_count_out = werr_q;
  assign bit_err_count_out  = berr_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Self-checking bench for prbs16_checker: a behavioural reference model feeds a
// scoreboard queue each driven cycle; DUT outputs are popped and compared after the edge.
module tb_prbs16_checker;

  localparam int LOCK_COUNT   = 4;
  localparam int UNLOCK_COUNT = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] word_in = 16'h0000;
  logic        locked_out;
  logic        err_out;
  logic [15:0] word_err_count_out;
  logic [23:0] bit_err_count_out;

  prbs16_checker #(
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .valid_in          (valid_in),
    .word_in           (word_in),
    .locked_out        (locked_out),
    .err_out           (err_out),
    .word_err_count_out(word_err_count_out),
    .bit_err_count_out (bit_err_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [15:0] werr;
    logic [23:0] berr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  logic        m_locked, m_seeded, m_err;
  logic [15:0] m_exp;
  int          m_match, m_miss, m_werr, m_berr;
  logic [15:0] gen_q;

  // Galois form of the generator step
  function automatic logic [15:0] gnext(input logic [15:0] q);
    return {q[14:0], 1'b0} ^ (q[15] ? 16'h8005 : 16'h0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [15:0] w);
    logic [15:0] diff;
    exp_t e;
    m_err = 1'b0;
    if (r) begin
      m_locked = 0; m_seeded = 0; m_exp = 0; m_match = 0; m_miss = 0; m_werr = 0; m_berr = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (w == 16'h0000) begin
          m_seeded = 0; m_match = 0;
        end else if (m_seeded && w == m_exp) begin
          m_exp = gnext(w);
          m_match++;
          if (m_match == LOCK_COUNT) begin m_locked = 1; m_miss = 0; end
        end else begin
          m_exp = gnext(w); m_seeded = 1; m_match = 0;
        end
      end else begin
        diff  = w ^ m_exp;
        m_exp = gnext(m_exp);
        if (diff == 16'h0000) m_miss = 0;
        else begin
          m_err  = 1'b1;
          m_werr = (m_werr + 1 > 32'hFFFF) ? 32'hFFFF : m_werr + 1;
          m_berr = (m_berr + $countones(diff) > 32'hFFFFFF) ? 32'hFFFFFF : m_berr + $countones(diff);
          m_miss++;
          if (m_miss == UNLOCK_COUNT) begin
            m_locked = 0; m_match = 0;
            if (w == 16'h0000) m_seeded = 0;
            else begin m_seeded = 1; m_exp = gnext(w); end
          end
        end
      end
    end
    e.locked = m_locked;
    e.err    = m_err;
    e.werr   = m_werr[15:0];
    e.berr   = m_berr[23:0];
    sb_q.push_back(e);
  endtask

  // Drive one cycle, advance the model, then compare the registered outputs.
  task automatic cyc(input logic r, input logic v, input logic [15:0] w);
    exp_t e;
    rst_in   = r;
    valid_in = v;
    word_in  = w;
    model_step(r, v, w);
    @(posedge clk_in);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("locked", {31'd0, locked_out}, {31'd0, e.locked});
      check("err", {31'd0, err_out}, {31'd0, e.err});
      check("werr", {16'd0, word_err_count_out}, {16'd0, e.werr});
      check("berr", {8'd0, bit_err_count_out}, {8'd0, e.berr});
    end
  endtask

  task automatic send_gen(input logic [15:0] flip);
    cyc(1'b0, 1'b1, gen_q ^ flip);
    gen_q = gnext(gen_q);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'($urandom));
  endtask

  initial begin
    cyc(1'b1, 1'b1, 16'h1234);
    cyc(1'b1, 1'b0, 16'h0000);
    check("rst_all", {7'd0, locked_out, err_out, word_err_count_out, bit_err_count_out[6:0]}, 32'd0);

    // lock from 0x8000: seed + four matches
    gen_q = 16'h8000;
    for (int i = 1; i <= 5; i++) begin
      send_gen(16'h0000);
      check("lock_seq", {31'd0, locked_out}, (i == 5) ? 32'd1 : 32'd0);
    end
    check("lock_werr0", {16'd0, word_err_count_out}, 32'd0);
    idle(2);

    // single corrupted word while locked: bits 0 and 3
    send_gen(16'h0009);
    check("one_err_pulse", {31'd0, err_out}, 32'd1);
    check("one_err_werr", {16'd0, word_err_count_out}, 32'd1);
    check("one_err_berr", {8'd0, bit_err_count_out}, 32'd2);
    check("one_err_lock", {31'd0, locked_out}, 32'd1);
    send_gen(16'h0000);
    check("flywheel_ok", {30'd0, locked_out, err_out}, 32'd2);

    // four consecutive corrupted words drop lock
    send_gen(16'h0001);
    send_gen(16'h0300);
    send_gen(16'hF000);
    check("miss3_lock", {31'd0, locked_out}, 32'd1);
    send_gen(16'h0010);
    check("unlock", {31'd0, locked_out}, 32'd0);
    check("unlock_werr", {16'd0, word_err_count_out}, 32'd5);
    check("unlock_berr", {8'd0, bit_err_count_out}, 32'd10);
    for (int i = 1; i <= 5; i++) begin
      send_gen(16'h0000);
      check("relock", {30'd0, locked_out, err_out}, (i == 5) ? 32'd2 : 32'd0);
    end

    // all-zero words in HUNT never seed or lock
    cyc(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 16'h0000);
    check("zero_hunt", {30'd0, locked_out, err_out}, 32'd0);

    // random valid gaps: same lock timing in words
    gen_q = 16'hACE1;
    for (int i = 1; i <= 5; i++) begin
      idle($urandom_range(0, 3));
      send_gen(16'h0000);
      check("gap_lock", {31'd0, locked_out}, (i == 5) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 3));
      send_gen(($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0000);
    end
    for (int i = 0; i < 6; i++) send_gen(16'h0000);

    // reset together with a valid word while locked
    cyc(1'b1, 1'b1, gen_q);
    gen_q = gnext(gen_q);
    check("rst_lock", {7'd0, locked_out, err_out, word_err_count_out, bit_err_count_out[6:0]}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      send_gen(16'h0000);
      check("post_rst_lock", {31'd0, locked_out}, (i == 5) ? 32'd1 : 32'd0);
    end

    // random mixed traffic including zeros and reseeds
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       cyc(1'b0, 1'b1, 16'h0000);
        1, 2:    send_gen(16'($urandom));
        3:       idle(1);
        default: send_gen(16'h0000);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
